// File: rtl/chacha20_stream_decryptor_pkg.sv
// Shared ChaCha20 definitions used by the stream decryptor and the encoder-side
// users of the same core.
// Contents: sigma constants, word/block widths, the decryptor FSM state enum,
// and the 512-bit block-state assembly function.
package chacha20_stream_decryptor_pkg;

  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 512;
  localparam int WORDS_PER_BLOCK = 16;

  localparam logic [WORD_W-1:0] SIGMA0 = 32'h6170_7865;
  localparam logic [WORD_W-1:0] SIGMA1 = 32'h3320_646e;
  localparam logic [WORD_W-1:0] SIGMA2 = 32'h7962_2d32;
  localparam logic [WORD_W-1:0] SIGMA3 = 32'h6b20_6574;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_STREAM
  } state_e;

  // Word i of the block lives at bits [32i+31:32i]: sigma in words 0..3,
  // key in 4..11, counter in 12, nonce in 13..15.
  function automatic logic [BLOCK_W-1:0] chacha20_assemble_state(
    input logic [255:0]      key,
    input logic [WORD_W-1:0] counter,
    input logic [95:0]       nonce
  );
    return {nonce, counter, key, SIGMA3, SIGMA2, SIGMA1, SIGMA0};
  endfunction

endpackage

// File: rtl/chacha20_keystream_buffer.sv
// Holds one 512-bit keystream block and selects the 32-bit word for the
// current position in the block.
// Ports:
//   clock, clear_n      clock and synchronous active-low reset
//   load_i, block_i     capture a new block and rewind the word index to 0
//   advance_i           step to the next word of the block
//   word_o, index_o     selected keystream word and its index
module chacha20_keystream_buffer
  import chacha20_stream_decryptor_pkg::*;
(
  input  logic               clock,
  input  logic               clear_n,
  input  logic               load_i,
  input  logic [BLOCK_W-1:0] block_i,
  input  logic               advance_i,
  output logic [WORD_W-1:0]  word_o,
  output logic [3:0]         index_o
);

  logic [BLOCK_W-1:0] ks_q;
  logic [3:0]         index_q;

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      ks_q    <= '0;
      index_q <= '0;
    end else if (load_i) begin
      ks_q    <= block_i;
      index_q <= '0;
    end else if (advance_i) begin
      index_q <= index_q + 4'd1;
    end
  end

  assign word_o  = ks_q[{index_q, 5'd0} +: WORD_W];
  assign index_o = index_q;

endmodule

// File: rtl/chacha20_stream_decryptor.sv
// Streaming ChaCha20 decryptor: drives an external ChaCha20 core to produce
// keystream blocks and XORs them against incoming 32-bit ciphertext words.
// The block counter advances every 16 words; a counter wrap or a core that
// never finishes sets the sticky error flag.
// Ports:
//   clock, clear_n                      clock, synchronous active-low reset
//   start, key, nonce, ctr_init         message start and its parameters
//   busy, error                         status (error is sticky until start)
//   core_*                              initiator side of the ChaCha20 core
//   s_valid/s_ready/s_data/s_last       ciphertext input stream
//   m_valid/m_ready/m_data/m_last       plaintext output stream
//   dbg_state                           current FSM state
// Handshakes: a word transfers on the rising edge where valid and ready are
// both high; a producer holds valid and its data steady until that edge.
module chacha20_stream_decryptor
  import chacha20_stream_decryptor_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024  // must be at least 2
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic               start,
  input  logic [255:0]       key,
  input  logic [95:0]        nonce,
  input  logic [WORD_W-1:0]  ctr_init,
  output logic               busy,
  output logic               error,
  output logic               core_set_state,
  output logic               core_start_round,
  output logic [BLOCK_W-1:0] core_round_input,
  input  logic [BLOCK_W-1:0] core_round_output,
  input  logic               core_finished,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WORD_W-1:0]  s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WORD_W-1:0]  m_data,
  output logic               m_last,
  output state_e             dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // START is cycle 0; stopping the count here makes error/busy change
  // exactly TIMEOUT_CYCLES cycles after START.
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(TIMEOUT_CYCLES - 2);

  state_e               state_q;
  logic [255:0]         key_q;
  logic [95:0]          nonce_q;
  logic [WORD_W-1:0]    ctr_q;
  logic [CW-1:0]        wait_cnt_q;
  logic                 error_q;
  logic                 set_state_q;
  logic                 start_round_q;
  logic [BLOCK_W-1:0]   round_input_q;
  logic                 m_valid_q;
  logic [WORD_W-1:0]    m_data_q;
  logic                 m_last_q;

  logic [WORD_W-1:0]    ks_word;
  logic [3:0]           ks_index;
  logic                 s_hs;
  logic [WORD_W-1:0]    ctr_next;

  assign s_ready  = (state_q == ST_STREAM) && (!m_valid_q || m_ready);
  assign s_hs     = s_valid && s_ready;
  assign ctr_next = ctr_q + 32'd1;

  chacha20_keystream_buffer u_ks_buf (
    .clock     (clock),
    .clear_n   (clear_n),
    .load_i    ((state_q == ST_WAIT) && core_finished),
    .block_i   (core_round_output),
    .advance_i (s_hs && !s_last && (ks_index != 4'd15)),
    .word_o    (ks_word),
    .index_o   (ks_index)
  );

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q       <= ST_IDLE;
      key_q         <= '0;
      nonce_q       <= '0;
      ctr_q         <= '0;
      wait_cnt_q    <= '0;
      error_q       <= 1'b0;
      set_state_q   <= 1'b0;
      start_round_q <= 1'b0;
      round_input_q <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_last_q      <= 1'b0;
    end else begin
      set_state_q   <= 1'b0;
      start_round_q <= 1'b0;

      // The output register keeps draining whatever state the FSM is in.
      if (s_hs) begin
        m_valid_q <= 1'b1;
        m_data_q  <= s_data ^ ks_word;
        m_last_q  <= s_last;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            key_q         <= key;
            nonce_q       <= nonce;
            ctr_q         <= ctr_init;
            error_q       <= 1'b0;
            set_state_q   <= 1'b1;
            round_input_q <= chacha20_assemble_state(key, ctr_init, nonce);
            state_q       <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          start_round_q <= 1'b1;
          state_q       <= ST_START;
        end
        ST_START: begin
          wait_cnt_q <= '0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_finished) begin
            state_q <= ST_STREAM;
          end else if (wait_cnt_q == WAIT_LIMIT) begin
            error_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        ST_STREAM: begin
          if (s_hs) begin
            if (s_last) begin
              // Rest of the keystream block is dropped; counter stays put.
              state_q <= ST_IDLE;
            end else if (ks_index == 4'd15) begin
              ctr_q <= ctr_next;
              if (ctr_q == 32'hFFFF_FFFF) error_q <= 1'b1;
              set_state_q   <= 1'b1;
              round_input_q <= chacha20_assemble_state(key_q, ctr_next, nonce_q);
              state_q       <= ST_LOAD;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy             = (state_q != ST_IDLE);
  assign error            = error_q;
  assign core_set_state   = set_state_q;
  assign core_start_round = start_round_q;
  assign core_round_input = round_input_q;
  assign m_valid          = m_valid_q;
  assign m_data           = m_data_q;
  assign m_last           = m_last_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_chacha20_stream_decryptor.sv
module tb_chacha20_stream_decryptor;

  localparam int T = 1024;

  logic         clock;
  logic         clear_n;
  logic         start;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  ctr_init;
  logic         busy, error;
  logic         core_set_state, core_start_round;
  logic [511:0] core_round_input;
  logic [511:0] core_round_output;
  logic         core_finished;
  logic         s_valid, s_ready, s_last;
  logic [31:0]  s_data;
  logic         m_valid, m_ready, m_last;
  logic [31:0]  m_data;
  logic [2:0]   dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0]  exp_q[$];   // {last, data}
  logic [31:0]  load_ctrs[$];
  logic [511:0] last_load;
  bit           core_dead = 0;
  int           set_long  = 0;

  chacha20_stream_decryptor #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .clear_n(clear_n), .start(start), .key(key), .nonce(nonce),
    .ctr_init(ctr_init), .busy(busy), .error(error),
    .core_set_state(core_set_state), .core_start_round(core_start_round),
    .core_round_input(core_round_input), .core_round_output(core_round_output),
    .core_finished(core_finished), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  // ---------------- reference ChaCha20 ----------------
  function automatic logic [127:0] qr(input logic [31:0] a_in, b_in, c_in, d_in);
    logic [31:0] a, b, c, d;
    a = a_in; b = b_in; c = c_in; d = d_in;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] ref_block(input logic [511:0] st);
    int qi[8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                     '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
    logic [31:0]  x[16];
    logic [127:0] t;
    logic [511:0] r;
    for (int i = 0; i < 16; i++) x[i] = st[32*i +: 32];
    for (int rd = 0; rd < 10; rd++) begin
      for (int q = 0; q < 8; q++) begin
        t = qr(x[qi[q][0]], x[qi[q][1]], x[qi[q][2]], x[qi[q][3]]);
        x[qi[q][0]] = t[127:96];
        x[qi[q][1]] = t[95:64];
        x[qi[q][2]] = t[63:32];
        x[qi[q][3]] = t[31:0];
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + st[32*i +: 32];
    return r;
  endfunction

  function automatic logic [511:0] ref_state(input logic [255:0] k, input logic [31:0] c,
                                             input logic [95:0] nc);
    logic [31:0]  w[16];
    logic [511:0] r;
    w[0] = 32'h61707865; w[1] = 32'h3320646e; w[2] = 32'h79622d32; w[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) w[4+i] = k[32*i +: 32];
    w[12] = c;
    for (int i = 0; i < 3; i++) w[13+i] = nc[32*i +: 32];
    for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i];
    return r;
  endfunction

  // ---------------- core model ----------------
  initial begin
    logic [511:0] st;
    bit  pending, prev_set;
    int  lat;
    core_finished = 0; core_round_output = '0;
    pending = 0; prev_set = 0; lat = 0; st = '0;
    forever begin
      @(negedge clock);
      core_finished = 0;
      if (core_set_state && prev_set) set_long++;
      prev_set = core_set_state;
      if (!clear_n) pending = 0;
      if (core_set_state) begin
        st = core_round_input;
        last_load = core_round_input;
        load_ctrs.push_back(core_round_input[415:384]);
      end
      if (core_start_round && !core_dead) begin
        pending = 1;
        lat = $urandom_range(0, 5);
      end else if (pending) begin
        if (lat == 0) begin
          core_finished = 1;
          core_round_output = ref_block(st);
          pending = 0;
        end else lat--;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [255:0] k, input logic [95:0] nc, input logic [31:0] c0);
    @(negedge clock);
    key = k; nonce = nc; ctr_init = c0; start = 1;
    @(negedge clock);
    start = 0;
  endtask

  // mode 0: always ready/valid; 1: random; 2: stall m_ready 5 cycles after first word
  task automatic run_message(input logic [255:0] k, input logic [95:0] nc, input logic [31:0] c0,
                             input int n, input int mode, input string tag);
    logic [31:0]  ct[$];
    logic [511:0] ks;
    logic [32:0]  exp, got;
    bit exp_err, hs;
    int sent, rcvd, cyc, stall, nblk;
    exp_q.delete();
    load_ctrs.delete();
    ks = '0;
    for (int i = 0; i < n; i++) begin
      ct.push_back($urandom);
      if (i % 16 == 0) ks = ref_block(ref_state(k, c0 + 32'(i / 16), nc));
      exp_q.push_back({(i == n - 1), ct[i] ^ ks[32*(i%16) +: 32]});
    end
    nblk = 1 + (n - 1) / 16;
    exp_err = 0;
    for (int b = 0; b < nblk - 1; b++) if (c0 + 32'(b) == 32'hFFFF_FFFF) exp_err = 1;

    pulse_start(k, nc, c0);
    n_checks++;
    if (error !== 1'b0 || busy !== 1'b1)
      $display("FAIL %s start_status: error=%b busy=%b expected error=0 busy=1", tag, error, busy);
    else n_pass++;

    sent = 0; rcvd = 0; cyc = 0; stall = 0; hs = 0;
    while (rcvd < n && cyc < 5000) begin
      @(negedge clock);
      cyc++;
      if (hs) begin sent++; s_valid = 0; end
      if (sent < n) begin
        if (!s_valid) s_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_data = ct[sent];
        s_last = (sent == n - 1);
      end
      if (mode == 1) m_ready = 1'($urandom_range(0, 1));
      else if (mode == 2 && sent >= 1 && stall < 5) begin m_ready = 0; stall++; end
      else m_ready = 1;
      #1;
      if (mode == 2 && !m_ready) begin
        n_checks++;
        if (s_ready !== 1'b0)
          $display("FAIL %s stall_s_ready: got %b expected 0 (stall cycle %0d)", tag, s_ready, stall);
        else n_pass++;
        if (stall == 5) begin
          n_checks++;
          if (sent != 1) $display("FAIL %s stall_accepted: got %0d words expected 1", tag, sent);
          else n_pass++;
        end
      end
      if (m_valid && m_ready) begin
        n_checks++;
        got = {m_last, m_data};
        if (exp_q.size() == 0)
          $display("FAIL %s extra_output: got %h expected no word", tag, got);
        else begin
          exp = exp_q.pop_front();
          if (got !== exp) $display("FAIL %s word%0d: got %h expected %h", tag, rcvd, got, exp);
          else n_pass++;
        end
        rcvd++;
      end
      hs = s_valid && s_ready;
    end
    @(negedge clock);
    s_valid = 0; s_last = 0; m_ready = 0;

    n_checks++;
    if (rcvd != n) $display("FAIL %s word_count: got %0d expected %0d", tag, rcvd, n);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s end_busy: got %b expected 0", tag, busy);
    else n_pass++;
    n_checks++;
    if (error !== exp_err) $display("FAIL %s end_error: got %b expected %b", tag, error, exp_err);
    else n_pass++;
    n_checks++;
    if (load_ctrs.size() != nblk)
      $display("FAIL %s block_loads: got %0d expected %0d", tag, load_ctrs.size(), nblk);
    else begin
      n_pass++;
      for (int b = 0; b < nblk; b++) begin
        n_checks++;
        if (load_ctrs[b] !== c0 + 32'(b))
          $display("FAIL %s load_ctr%0d: got %h expected %h", tag, b, load_ctrs[b], c0 + 32'(b));
        else n_pass++;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_n = 0; start = 0; key = '0; nonce = '0; ctr_init = '0;
    s_valid = 0; s_data = '0; s_last = 0; m_ready = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    clear_n = 1;
    n_checks++;
    if ({busy, error, core_set_state, core_start_round, s_ready, m_valid, m_last} !== 7'b0)
      $display("FAIL reset_flags: got %b expected 0000000",
               {busy, error, core_set_state, core_start_round, s_ready, m_valid, m_last});
    else n_pass++;
    n_checks++;
    if (m_data !== 32'h0) $display("FAIL reset_m_data: got %h expected 0", m_data);
    else n_pass++;
    n_checks++;
    if (core_round_input !== 512'h0) $display("FAIL reset_round_input: got %h expected 0", core_round_input);
    else n_pass++;
  endtask

  task automatic test_rfc_vector();
    logic [255:0] k;
    int cyc;
    for (int b = 0; b < 32; b++) k[8*b +: 8] = 8'(b);
    pulse_start(k, 96'h0000_0000_4a00_0000_0000_0000, 32'd1);
    cyc = 0;
    m_ready = 1;
    do begin
      @(negedge clock);
      cyc++;
      #1;
    end while (!s_ready && cyc < 100);
    n_checks++;
    if (!s_ready) $display("FAIL rfc_ready: got s_ready=0 expected 1 within 100 cycles");
    else n_pass++;
    n_checks++;
    if (last_load[31:0] !== 32'h61707865 || last_load[159:128] !== 32'h03020100 ||
        last_load[415:384] !== 32'h1 || last_load[479:448] !== 32'h4a000000)
      $display("FAIL rfc_state: got w0=%h w4=%h w12=%h w14=%h expected 61707865 03020100 00000001 4a000000",
               last_load[31:0], last_load[159:128], last_load[415:384], last_load[479:448]);
    else n_pass++;
    n_checks++;
    if (m_valid !== 1'b0) $display("FAIL rfc_pre_valid: got %b expected 0", m_valid);
    else n_pass++;
    s_valid = 1; s_data = 32'h9a352e6e; s_last = 1;
    @(negedge clock);
    s_valid = 0; s_last = 0;
    n_checks++;
    if ({m_valid, m_last, m_data} !== {1'b1, 1'b1, 32'h6964614c})
      $display("FAIL rfc_plaintext: got valid=%b last=%b data=%h expected 1 1 6964614c",
               m_valid, m_last, m_data);
    else n_pass++;
    @(negedge clock);
    m_ready = 0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rfc_idle: got busy=%b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_block_boundary();
    run_message({8{$urandom}}, {3{$urandom}}, 32'd1, 17, 0, "boundary");
    n_checks++;
    if (set_long != 0) $display("FAIL set_state_width: got %0d long pulses expected 0", set_long);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    run_message({8{$urandom}}, {3{$urandom}}, $urandom, 10, 2, "backpressure");
  endtask

  task automatic test_timeout();
    int cyc, i;
    core_dead = 1;
    pulse_start({8{$urandom}}, {3{$urandom}}, $urandom);
    cyc = 0;
    while (!core_start_round && cyc < 20) begin @(negedge clock); cyc++; end
    n_checks++;
    if (!core_start_round) $display("FAIL timeout_start_round: got 0 expected 1 within 20 cycles");
    else n_pass++;
    i = 0;
    do begin
      @(negedge clock);
      i++;
    end while (!error && i < T + 10);
    n_checks++;
    if (i != T) $display("FAIL timeout_latency: got %0d cycles expected %0d", i, T);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL timeout_busy: got %b expected 0", busy);
    else n_pass++;
    core_dead = 0;
    run_message({8{$urandom}}, {3{$urandom}}, $urandom, 5, 1, "after_timeout");
  endtask

  task automatic test_counter_wrap();
    run_message({8{$urandom}}, {3{$urandom}}, 32'hFFFF_FFFF, 20, 0, "wrap");
  endtask

  task automatic test_reset_mid_stream();
    int cnt, cyc;
    bit hs;
    pulse_start({8{$urandom}}, {3{$urandom}}, $urandom);
    cnt = 0; cyc = 0; hs = 0;
    while (cnt < 7 && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (hs) cnt++;
      s_valid = (cnt < 7); s_data = $urandom; s_last = 0; m_ready = 1;
      #1;
      hs = s_valid && s_ready;
    end
    s_valid = 0; m_ready = 0;
    clear_n = 0;
    @(negedge clock);
    clear_n = 1;
    n_checks++;
    if ({busy, error, core_set_state, core_start_round, s_ready, m_valid, m_last} !== 7'b0)
      $display("FAIL midreset_flags: got %b expected 0000000",
               {busy, error, core_set_state, core_start_round, s_ready, m_valid, m_last});
    else n_pass++;
    n_checks++;
    if (m_data !== 32'h0 || core_round_input !== 512'h0)
      $display("FAIL midreset_data: got m_data=%h round_input_w12=%h expected 0 0",
               m_data, core_round_input[415:384]);
    else n_pass++;
    run_message({8{$urandom}}, {3{$urandom}}, $urandom, 3, 0, "after_reset");
  endtask

  task automatic test_random_messages();
    for (int m = 0; m < 6; m++)
      run_message({8{$urandom}}, {3{$urandom}}, $urandom, $urandom_range(1, 40), 1, "random");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_rfc_vector();
    test_block_boundary();
    test_backpressure();
    test_counter_wrap();
    test_timeout();
    test_reset_mid_stream();
    test_random_messages();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/chacha20_stream_decryptor.md
Name: chacha20_stream_decryptor

Overview:
- Drives a chacha20_serial_encoder core to turn keystream blocks into a streaming 32-bit ciphertext-to-plaintext XOR path.
- Sits on the initiator side of the core's set_state / start_round / round_input / round_output / finished interface; the core instance lives outside this block.
- Builds each 512-bit block state from a latched key, nonce and counter, then XORs the keystream against incoming ciphertext words.
- Advances the block counter every 16 words, so it is the decrypt counterpart of the LED RNG consumer.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles in WAIT before error is flagged.

Ports:
- clock  in  1  single clock.
- clear_n  in  1  synchronous active-low reset.
- start  in  1  pulse; latches key, nonce and ctr_init; ignored unless IDLE.
- key  in  256  ChaCha20 key, state words 4..11, word i = bits[32(i-4)+31 : 32(i-4)].
- nonce  in  96  state words 13..15.
- ctr_init  in  32  initial block counter, state word 12.
- busy  out  1  high in any state other than IDLE.
- error  out  1  sticky; set on core timeout or counter wrap; cleared by start or reset.
- core_set_state  out  1  load pulse to the core.
- core_start_round  out  1  start pulse to the core.
- core_round_input  out  512  block state to the core.
- core_round_output  in  512  keystream from the core (feed-forward already applied).
- core_finished  in  1  core done strobe.
- s_valid  in  1  ciphertext handshake.
- s_ready  out  1  ciphertext handshake.
- s_data  in  32  ciphertext word.
- s_last  in  1  final word of the message.
- m_valid  out  1  plaintext handshake.
- m_ready  in  1  plaintext handshake.
- m_data  out  32  plaintext word.
- m_last  out  1  final word of the message.

Behaviour:
- Reset (clear_n=0 at clock edge), from any state including mid-block:
  - state=IDLE.
  - busy, error, core_set_state, core_start_round, s_ready, m_valid, m_last = 0.
  - m_data=0, core_round_input=0, word index=0, counter=0.
- Block state layout:
  - Words 0..3 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574.
  - Words 4..11 = key; word 12 = counter; words 13..15 = nonce.
  - Word i occupies bits[32i+31:32i].
- FSM:
  - IDLE: on start, latch key, nonce, ctr_init; clear error; go to LOAD.
  - LOAD: core_set_state=1 for exactly one cycle with core_round_input valid; go to START.
  - START: core_start_round=1 for one cycle; clear the wait counter; go to WAIT.
  - WAIT: on core_finished=1, capture core_round_output into the keystream register, set word index=0, go to STREAM. If the wait counter reaches TIMEOUT_CYCLES first, set error and go to IDLE.
  - STREAM: s_ready = !m_valid | m_ready.
- On an s handshake in STREAM:
  - m_data <= s_data XOR keystream word[index]; m_last <= s_last; m_valid <= 1 on the next cycle (latency 1).
  - If s_last: go to IDLE; remaining keystream is discarded and the counter is not incremented.
  - Else if index==15: counter <= counter+1 (mod 2^32), go to LOAD.
  - Else: index+1.
- Counter wrap: if the increment takes 0xFFFFFFFF to 0, set error; processing continues.
- m_valid clears on m_ready when no new handshake occurs the same cycle. A simultaneous accept and new word keeps m_valid=1.
- s_ready=0 in IDLE, LOAD, START and WAIT; the output register still drains during these states.
- core_finished outside WAIT is ignored.
- start while busy is ignored.
- Throughput: 16 words per block, plus a LOAD/START/WAIT stall between blocks.

Decomposition:
- Shared chacha20 package:
  - The four sigma constants.
  - Word/block widths (32/512).
  - FSM state enum.
  - State-assembly function (key, counter, nonce → 512 bits), reused by the encoder-side users.
- One natural sub-module: chacha20_keystream_buffer, which holds the 512-bit register, the word index and the word select.

Test Plan:
- RFC 8439 §2.4.2 vector: key 00..1f, nonce 000000000000004a00000000, ctr_init=1, core model returns the RFC keystream; s_data=0x9a352e6e → m_data=0x6964614c, one cycle after handshake.
- Block boundary: 17-word message → after word 16, core_set_state pulses with word 12 = 2; word 17 decrypts with the block-2 keystream; m_last only on word 17.
- Backpressure: m_ready=0 for 5 cycles with s_valid=1 → s_ready=0 after the first word; no loss or duplication; order preserved.
- Timeout: core_finished never asserted → error=1 and busy=0 exactly TIMEOUT_CYCLES cycles after START; a subsequent start clears error.
- Counter wrap: ctr_init=0xFFFFFFFF, 20 words → second block uses counter 0 and error=1.
- Reset mid-STREAM: clear_n=0 for one cycle at word 7 → all outputs at reset values; a new start produces the correct first word.
